// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
// State encodings, address constants and the state-to-strobe decode.
package router_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam logic [2:0] ST_DA  = 3'd0;
  localparam logic [2:0] ST_LFD = 3'd1;
  localparam logic [2:0] ST_LD  = 3'd2;
  localparam logic [2:0] ST_FFS = 3'd3;
  localparam logic [2:0] ST_LAF = 3'd4;
  localparam logic [2:0] ST_LP  = 3'd5;
  localparam logic [2:0] ST_CPE = 3'd6;
  localparam logic [2:0] ST_WTE = 3'd7;

  typedef enum logic [2:0] {
    S_DA  = ST_DA,
    S_LFD = ST_LFD,
    S_LD  = ST_LD,
    S_FFS = ST_FFS,
    S_LAF = ST_LAF,
    S_LP  = ST_LP,
    S_CPE = ST_CPE,
    S_WTE = ST_WTE
  } state_t;

  typedef struct packed {
    logic detect_add;
    logic lfd;
    logic ld;
    logic full;
    logic laf;
    logic rst_int;
    logic write_enb;
    logic busy;
  } strobes_t;

  function automatic logic addr_valid(
    input logic [1:0] addr
  );
    return addr != ADDR_INVALID;
  endfunction

  function automatic strobes_t decode_state(
    input state_t s
  );
    strobes_t st;
    st.detect_add = (s == S_DA);
    st.lfd        = (s == S_LFD);
    st.ld         = (s == S_LD);
    st.full       = (s == S_FFS);
    st.laf        = (s == S_LAF);
    st.rst_int    = (s == S_CPE);
    st.write_enb  = (s == S_LD)
                 || (s == S_LP)
                 || (s == S_LAF);
    st.busy       = (s == S_LFD)
                 || (s == S_FFS)
                 || (s == S_LAF)
                 || (s == S_LP)
                 || (s == S_CPE)
                 || (s == S_WTE);
    return st;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Wait-till-empty timeout counter for the router controller.
// Only built when ROUTER_WAIT_TIMEOUT_EN is defined.
`ifdef ROUTER_WAIT_TIMEOUT_EN
module router_wait_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count;

  // Count cycles spent waiting; held at zero outside the wait.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  assign expire = enable && (count == LAST);

endmodule
`endif

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM for the 1x3 router (header, payload, stall, parity).
// Define ROUTER_WAIT_TIMEOUT_EN to drop packets stuck waiting for an empty FIFO.
module router_fsm_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [1:0]           data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [1:0]           dest_addr,
  output logic                 drop_pkt
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("router_fsm_ctrl: TIMEOUT_CYCLES must be >= 2");
  end

  state_t   state;
  state_t   state_nxt;
  strobes_t st;
  logic     hdr_ok;
  logic     hdr_empty;
  logic     tgt_empty;
  logic     sr_hit;
  logic     timeout;

  assign hdr_ok    = pkt_valid && addr_valid(data_in);
  assign hdr_empty = fifo_empty[data_in];
  assign tgt_empty = fifo_empty[dest_addr];
  assign sr_hit    = soft_reset[dest_addr];

`ifdef ROUTER_WAIT_TIMEOUT_EN
  router_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (state != S_WTE),
    .enable (state == S_WTE),
    .expire (timeout)
  );

  // One-cycle drop flag, lands together with the return to DA.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      drop_pkt <= 1'b0;
    end else begin
      drop_pkt <= timeout && !tgt_empty;
    end
  end
`else
  assign timeout  = 1'b0;
  assign drop_pkt = 1'b0;
`endif

  // State register; reset wins even mid-packet.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_DA;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the destination port from a valid header.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dest_addr <= 2'b00;
    end else if (state == S_DA && hdr_ok) begin
      dest_addr <= data_in;
    end
  end

  // Next-state table; soft reset of the active port aborts to DA.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_DA: begin
        if (hdr_ok) begin
          state_nxt = hdr_empty ? S_LFD : S_WTE;
        end
      end
      S_LFD: begin
        state_nxt = S_LD;
      end
      S_LD: begin
        if (fifo_full) begin
          state_nxt = S_FFS;
        end else if (!pkt_valid) begin
          state_nxt = S_LP;
        end
      end
      S_FFS: begin
        if (!fifo_full) begin
          state_nxt = S_LAF;
        end
      end
      S_LAF: begin
        if (parity_done) begin
          state_nxt = S_DA;
        end else if (low_pkt_valid) begin
          state_nxt = S_LP;
        end else begin
          state_nxt = S_LD;
        end
      end
      S_LP: begin
        state_nxt = S_CPE;
      end
      S_CPE: begin
        state_nxt = fifo_full ? S_FFS : S_DA;
      end
      S_WTE: begin
        if (tgt_empty) begin
          state_nxt = S_LFD;
        end else if (timeout) begin
          state_nxt = S_DA;
        end
      end
      default: begin
        state_nxt = S_DA;
      end
    endcase
    if (state != S_DA && sr_hit) begin
      state_nxt = S_DA;
    end
  end

  assign st            = decode_state(state);
  assign detect_add    = st.detect_add;
  assign lfd_state     = st.lfd;
  assign ld_state      = st.ld;
  assign full_state    = st.full;
  assign laf_state     = st.laf;
  assign rst_int_reg   = st.rst_int;
  assign write_enb_reg = st.write_enb;
  assign busy          = st.busy;

endmodule
